// File: rtl/flash_audio_streamer.sv
// flash_audio_streamer: fetches PCM frames from byte-wide flash into a frame FIFO and plays them MSB-first on a serial DAC port
// Ports: CLK/Reset; start/stop/loop/base_addr/num_frames playback control; FL_ADDR/FL_DQ flash;
//        AUD_BCLK/AUD_DACLRCK/AUD_DACDAT serial audio; busy/done/underflow_cnt status.
module flash_audio_streamer #(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FL_WAIT    = 5,
  parameter int BCLK_DIV   = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic [22:0] base_addr,
  input  logic [22:0] num_frames,
  output logic [22:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        busy,
  output logic        done,
  output logic [7:0]  underflow_cnt
);
  localparam int FW = NUM_CH * SAMPLE_W;
  localparam int NB = FW / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(NB + 1);
  localparam int WW = $clog2(FL_WAIT + 2);
  localparam int DW = $clog2(BCLK_DIV) + 1;
  localparam int CW = $clog2(FW + 1);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPT, PUSH} state_t;
  state_t state, nxt;
  logic [22:0] fidx, base_r, nf_r;
  logic [BW-1:0] bidx;
  logic [WW-1:0] wcnt;
  logic [FW-1:0] asm_r, sh;
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [DW-1:0] div;
  logic [CW-1:0] bit_i;
  logic fetch_done, loop_r, run;
  logic go, full, empty, push, pop, last_byte, last_frame, tick, fall, begin_run, bound, finish;
  assign go         = start && !stop && !busy && num_frames != '0;
  assign full       = cnt == (AW+1)'(FIFO_DEPTH);
  assign empty      = cnt == '0;
  assign push       = state == PUSH && !full;
  assign last_byte  = bidx == BW'(NB - 1);
  assign last_frame = fidx == nf_r - 23'd1;
  assign tick       = run && div == DW'(BCLK_DIV - 1);
  assign fall       = tick && AUD_BCLK;
  // playback waits for a full FIFO, or for the whole clip when it is shorter than the FIFO
  assign begin_run  = busy && !run && (full || fetch_done);
  assign bound      = begin_run || (fall && bit_i == CW'(FW - 1));
  assign pop        = bound && !empty;
  assign finish     = bound && empty && fetch_done;
  assign AUD_DACDAT = sh[FW-1];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? ADDR : IDLE;
      ADDR:    nxt = FL_WAIT == 0 ? CAPT : WAIT;
      WAIT:    nxt = wcnt == WW'(FL_WAIT - 1) ? CAPT : WAIT;
      CAPT:    nxt = last_byte ? PUSH : ADDR;
      PUSH:    nxt = !push ? PUSH : (last_frame && !loop_r) ? IDLE : ADDR;
      default: nxt = IDLE;
    endcase
    if (stop) nxt = IDLE;
  end
  always_ff @(posedge CLK) state <= Reset ? IDLE : nxt;
  always_ff @(posedge CLK) if (push) mem[wp] <= asm_r;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      FL_ADDR <= '0; fidx <= '0; bidx <= '0; wcnt <= '0; asm_r <= '0; sh <= '0;
      base_r <= '0; nf_r <= '0; loop_r <= 1'b0; fetch_done <= 1'b0;
      busy <= 1'b0; done <= 1'b0; underflow_cnt <= '0;
      wp <= '0; rp <= '0; cnt <= '0;
      run <= 1'b0; div <= '0; bit_i <= '0; AUD_BCLK <= 1'b0; AUD_DACLRCK <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        base_r <= base_addr; nf_r <= num_frames; loop_r <= loop; FL_ADDR <= base_addr;
        fidx <= '0; bidx <= '0; fetch_done <= 1'b0; underflow_cnt <= '0; busy <= 1'b1;
      end
      wcnt <= state == WAIT ? wcnt + WW'(1) : '0;
      if (state == CAPT) begin
        asm_r <= (asm_r << 8) | FW'(FL_DQ);
        bidx <= last_byte ? '0 : bidx + BW'(1);
        if (!last_byte) FL_ADDR <= FL_ADDR + 23'd1;
      end
      if (push) begin
        fidx <= last_frame ? '0 : fidx + 23'd1;
        FL_ADDR <= last_frame ? base_r : FL_ADDR + 23'd1;
        fetch_done <= last_frame && !loop_r;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (run) begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) AUD_BCLK <= ~AUD_BCLK;
        if (fall) begin
          sh <= sh << 1;
          bit_i <= bit_i + CW'(1);
          AUD_DACLRCK <= 1'b0;
        end
      end
      if (begin_run) run <= 1'b1;
      if (bound) begin
        sh <= pop ? mem[rp] : '0;
        bit_i <= '0;
        AUD_DACLRCK <= !finish;
        if (!pop && !finish && underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 8'd1;
        if (finish) begin
          run <= 1'b0; busy <= 1'b0; done <= 1'b1; AUD_BCLK <= 1'b0; div <= '0;
        end
      end
      if (stop) begin
        busy <= 1'b0; done <= 1'b0; fetch_done <= 1'b0;
        wp <= '0; rp <= '0; cnt <= '0;
        run <= 1'b0; div <= '0; sh <= '0; AUD_BCLK <= 1'b0; AUD_DACLRCK <= 1'b0;
      end
    end
  end
endmodule
